// File: rtl/hdlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_pkg
// Brief    : Shared types and constants for the HDLC run-length de-stuffer.
// Revision : 1.0 - initial release
// ============================================================================
package hdlc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam int DEF_RUN_LEN = 5;
  localparam int FLAG_ONES   = DEF_RUN_LEN + 1;

  // Ones that, followed by a 0, form a flag for a given run length.
  function automatic int calc_flag_ones(input int run_len);
    return run_len + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdlc_run_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_run_destuffer
// Brief    : Registered HDLC bit de-stuffer with flag/abort detection and a
//            valid/ready payload stream.
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_run_destuffer
  import hdlc_pkg::*;
#(
  parameter int RUN_LEN = 5,
  parameter int CNT_W   = $clog2(RUN_LEN + 3)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic din,
  output logic out_valid,
  input  logic out_ready,
  output logic dout,
  output logic flag,
  output logic abort,
  output logic stuff_rm,
  output logic in_frame
);

  localparam logic [CNT_W-1:0] C_FLAG  = CNT_W'(calc_flag_ones(RUN_LEN));
  localparam logic [CNT_W-1:0] C_STUFF = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             zero_q, zero_d;
  logic             frame_q, frame_d;
  logic             flag_q, flag_d;
  logic             abort_q, abort_d;
  logic             stuff_q, stuff_d;
  logic             w_accept;

  assign in_ready  = (state_q != DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign dout      = out_valid & (pend_q != '0);
  assign flag      = flag_q;
  assign abort     = abort_q;
  assign stuff_rm  = stuff_q;
  assign in_frame  = frame_q;
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
      zero_q  <= 1'b0;
      frame_q <= 1'b0;
      flag_q  <= 1'b0;
      abort_q <= 1'b0;
      stuff_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
      frame_q <= frame_d;
      flag_q  <= flag_d;
      abort_q <= abort_d;
      stuff_q <= stuff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    frame_d = frame_q;
    flag_d  = 1'b0;
    abort_d = 1'b0;
    stuff_d = 1'b0;
    case (state_q)
      RUN: begin
        if (w_accept) begin
          if (din) begin
            if (cnt_q == C_FLAG) begin
              state_d = ERR;
              abort_d = 1'b1;
              frame_d = 1'b0;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end else begin
            cnt_d = '0;
            if (cnt_q == C_FLAG) begin
              flag_d  = 1'b1;
              frame_d = 1'b1;
            end else begin
              stuff_d = (cnt_q == C_STUFF);
              // Held ones are only replayed when a frame is open.
              if (frame_q) begin
                state_d = DRAIN;
                pend_d  = cnt_q;
                zero_d  = (cnt_q != C_STUFF);
              end
            end
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (pend_q != '0) begin
            pend_d = pend_q - C_ONE;
            if ((pend_q == C_ONE) && !zero_q) begin
              state_d = RUN;
            end
          end else begin
            zero_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      ERR: begin
        if (w_accept && !din) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hdlc_run_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_run_destuffer
// Brief    : Self-checking bench for hdlc_run_destuffer (RUN_LEN=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdlc_run_destuffer;

  localparam int RUN_LEN = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic din = 1'b0;
  logic in_ready, out_valid, dout, flag, abort, stuff_rm, in_frame;
  logic out_ready;
  logic rdy_rand = 1'b0;
  logic rdy_man = 1'b1;
  logic rnd_rdy = 1'b1;

  int nvec = 0;
  int nerr = 0;

  int   m_ones = 0;
  logic m_frame = 1'b0;
  logic m_err = 1'b0;
  logic exp_q[$];
  logic got_q[$];

  hdlc_run_destuffer #(.RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .flag(flag), .abort(abort), .stuff_rm(stuff_rm), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  assign out_ready = rdy_rand ? rnd_rdy : rdy_man;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(dout);
  end

  // Reference: counts the current run of ones and applies the frame rules.
  function automatic logic [3:0] model_step(input logic b);
    logic f = 1'b0, a = 1'b0, s = 1'b0;
    if (m_err) begin
      if (!b) begin m_err = 1'b0; m_ones = 0; end
    end else if (b) begin
      if (m_ones == RUN_LEN + 1) begin a = 1'b1; m_frame = 1'b0; m_err = 1'b1; end
      else m_ones++;
    end else begin
      if (m_ones == RUN_LEN + 1) begin
        f = 1'b1; m_frame = 1'b1;
      end else begin
        s = (m_ones == RUN_LEN);
        if (m_frame) begin
          repeat (m_ones) exp_q.push_back(1'b1);
          if (m_ones < RUN_LEN) exp_q.push_back(1'b0);
        end
      end
      m_ones = 0;
    end
    return {f, a, s, m_frame};
  endfunction

  task automatic send_bit(input logic b, output logic [3:0] obs);
    int t = 0;
    in_valid = 1'b1;
    din = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      obs = 'x;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs = {flag, abort, stuff_rm, in_frame};
  endtask

  task automatic wait_idle(output logic ok);
    int t = 0;
    while (!(in_ready && !out_valid) && t < 500) begin @(posedge clk); #1; t++; end
    ok = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_ones = 0; m_frame = 1'b0; m_err = 1'b0;
    nvec++;
    if ({in_ready, out_valid, dout, flag, abort, stuff_rm, in_frame} !== 7'b1000000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {in_ready, out_valid, dout, flag, abort, stuff_rm, in_frame});
    end
  endtask

  task automatic test_flag();
    logic [7:0] pat = 8'b01111110;
    logic [3:0] o, e;
    for (int i = 7; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL flag_pulses bit%0d: got %b required %b", 7 - i, o, e); end
    end
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL flag_no_output: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_short_drain();
    logic [2:0] pat = 3'b110;
    logic [3:0] o, e;
    logic ok;
    rdy_man = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL drain_pulses bit%0d: got %b required %b", 2 - i, o, e); end
    end
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (in_ready !== (c == 3)) begin
        nerr++; $display("FAIL drain_in_ready cyc%0d: got %b required %b", c, in_ready, (c == 3));
      end
      @(posedge clk); #1;
    end
    wait_idle(ok);
    nvec++;
    if (!ok || got_q.size() != 3 || got_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL drain_stream_len: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL drain_stream[%0d]: got %b required %b", i, got_q[i], exp_q[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stuff();
    logic [7:0] pat = 8'b11111010;
    logic [3:0] o, e;
    logic ok;
    for (int i = 7; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL stuff_pulses bit%0d: got %b required %b", 7 - i, o, e); end
    end
    wait_idle(ok);
    nvec++;
    if (!ok || got_q.size() != 7 || got_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL stuff_stream_len: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL stuff_stream[%0d]: got %b required %b", i, got_q[i], exp_q[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    logic [11:0] pat = 12'b111111111010;
    logic [3:0] o, e;
    logic ok;
    for (int i = 11; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL abort_pulses bit%0d: got %b required %b", 11 - i, o, e); end
    end
    wait_idle(ok);
    nvec++;
    if (!ok || got_q.size() != 0 || exp_q.size() != 0) begin
      nerr++; $display("FAIL abort_no_output: got %0d bits required 0", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    logic [10:0] pat = 11'b01111110110;
    logic [3:0] o, e;
    logic ok;
    rdy_man = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL stall_pulses bit%0d: got %b required %b", 10 - i, o, e); end
    end
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if ({out_valid, dout, in_ready} !== 3'b110) begin
        nerr++; $display("FAIL stall_hold cyc%0d: got %b required 110", c, {out_valid, dout, in_ready});
      end
      @(posedge clk); #1;
    end
    rdy_man = 1'b1;
    wait_idle(ok);
    nvec++;
    if (!ok || got_q.size() != 3 || got_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL stall_stream_len: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL stall_stream[%0d]: got %b required %b", i, got_q[i], exp_q[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    logic [2:0] pat = 3'b110;
    logic [7:0] fl = 8'b01111110;
    logic [3:0] o, e;
    rdy_man = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      e = model_step(pat[i]);
      send_bit(pat[i], o);
    end
    nvec++;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_drain_entry: out_valid=%b required 1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_man = 1'b1;
    m_ones = 0; m_frame = 1'b0; m_err = 1'b0;
    got_q.delete(); exp_q.delete();
    nvec++;
    if ({out_valid, in_frame, in_ready, dout} !== 4'b0010) begin
      nerr++; $display("FAIL mid_drain_reset: got %b required 0010", {out_valid, in_frame, in_ready, dout});
    end
    // A cleared run counter means a fresh flag is recognised right away.
    for (int i = 7; i >= 0; i--) begin
      e = model_step(fl[i]);
      send_bit(fl[i], o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL post_reset_flag bit%0d: got %b required %b", 7 - i, o, e); end
    end
  endtask

  task automatic test_random();
    logic [3:0] o, e;
    logic b, ok;
    int n;
    rdy_rand = 1'b1;
    for (int k = 0; k < 600; k++) begin
      b = ($urandom_range(0, 99) < 72);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      e = model_step(b);
      send_bit(b, o);
      nvec++;
      if (o !== e) begin nerr++; $display("FAIL rand_pulses k=%0d: got %b required %b", k, o, e); end
    end
    wait_idle(ok);
    rdy_rand = 1'b0;
    nvec++;
    if (!ok || got_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL rand_stream_len: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      n = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin
          nerr++;
          if (n < 5) $display("FAIL rand_stream[%0d]: got %b required %b", i, got_q[i], exp_q[i]);
          n++;
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_flag();
    test_short_drain();
    test_stuff();
    test_abort();
    test_stall();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
